// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - dual-issue instruction fetch queue (64-bit packets in, two oldest instructions out).
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 10
) (
  input  logic                       clock_i,
  input  logic                       resetn_i,
  input  logic                       enq_valid_i,
  input  logic [63:0]                data_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic                       skip_lo_i,
  output logic                       imemstall_o,
  input  logic                       flush_i,
  input  logic [1:0]                 deq_cnt_i,
  output logic                       valid0_o,
  output logic                       valid1_o,
  output logic [31:0]                inst0_o,
  output logic [31:0]                inst1_o,
  output logic [ADDR_W+2:0]          pc0_o,
  output logic [ADDR_W+2:0]          pc1_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      inst_mem_d [DEPTH];
  logic [IDX_W-1:0] idx_mem_q  [DEPTH];
  logic [IDX_W-1:0] idx_mem_d  [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [CNT_W-1:0] count_q, count_d;

  logic             stall, enq_ok;
  logic [CNT_W-1:0] enq_n, deq_n, avail;
  logic [1:0]       deq_req;
  logic [31:0]      in0_inst, in1_inst, view0_inst, view1_inst;
  logic [IDX_W-1:0] in0_idx, in1_idx, view0_idx, view1_idx;

  always_comb begin
    stall    = count_q > CNT_W'(DEPTH - 2);
    enq_ok   = enq_valid_i & ~stall & ~flush_i;
    // With skip_lo_i the first instruction written is slot 1.
    in0_inst = skip_lo_i ? data_i[63:32] : data_i[31:0];
    in0_idx  = {addr_i, skip_lo_i};
    in1_inst = data_i[63:32];
    in1_idx  = {addr_i, 1'b1};
    enq_n    = enq_ok ? (skip_lo_i ? CNT_W'(1) : CNT_W'(2)) : '0;
    deq_req  = (deq_cnt_i == 2'd3) ? 2'd2 : deq_cnt_i;
    head1    = head_q + PTR_W'(1);
    tail1    = tail_q + PTR_W'(1);

    avail      = count_q;
    view0_inst = inst_mem_q[head_q];
    view0_idx  = idx_mem_q[head_q];
    view1_inst = inst_mem_q[head1];
    view1_idx  = idx_mem_q[head1];
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: present the incoming packet directly. It is still written at
    // the tail; head advancing past consumed entries discards them.
    if (count_q == '0 && enq_ok) begin
      avail      = enq_n;
      view0_inst = in0_inst;
      view0_idx  = in0_idx;
      view1_inst = in1_inst;
      view1_idx  = in1_idx;
    end
`endif
    deq_n = (CNT_W'(deq_req) > avail) ? avail : CNT_W'(deq_req);

    inst_mem_d = inst_mem_q;
    idx_mem_d  = idx_mem_q;
    if (enq_ok) begin
      inst_mem_d[tail_q] = in0_inst;
      idx_mem_d[tail_q]  = in0_idx;
      if (!skip_lo_i) begin
        inst_mem_d[tail1] = in1_inst;
        idx_mem_d[tail1]  = in1_idx;
      end
    end

    if (flush_i) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      count_d = count_q + enq_n - deq_n;
      head_d  = head_q + deq_n[PTR_W-1:0];
      tail_d  = tail_q + enq_n[PTR_W-1:0];
    end

    valid0_o    = avail >= CNT_W'(1);
    valid1_o    = avail >= CNT_W'(2);
    inst0_o     = valid0_o ? view0_inst : NOP;
    inst1_o     = valid1_o ? view1_inst : NOP;
    pc0_o       = valid0_o ? {view0_idx, 2'b00} : '0;
    pc1_o       = valid1_o ? {view1_idx, 2'b00} : '0;
    count_o     = count_q;
    imemstall_o = stall;
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Storage contents are don't-care after reset; only the pointers matter.
  always_ff @(posedge clock_i) begin
    inst_mem_q <= inst_mem_d;
    idx_mem_q  <= idx_mem_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 4;
  localparam int PC_W   = ADDR_W + 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clock_i, resetn_i, enq_valid_i, skip_lo_i, flush_i;
  logic [63:0]       data_i;
  logic [ADDR_W-1:0] addr_i;
  logic [1:0]        deq_cnt_i;
  logic              imemstall_o, valid0_o, valid1_o;
  logic [31:0]       inst0_o, inst1_o;
  logic [PC_W-1:0]   pc0_o, pc1_o;
  logic [CNT_W-1:0]  count_o;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock_i(clock_i), .resetn_i(resetn_i), .enq_valid_i(enq_valid_i),
    .data_i(data_i), .addr_i(addr_i), .skip_lo_i(skip_lo_i),
    .imemstall_o(imemstall_o), .flush_i(flush_i), .deq_cnt_i(deq_cnt_i),
    .valid0_o(valid0_o), .valid1_o(valid1_o), .inst0_o(inst0_o), .inst1_o(inst1_o),
    .pc0_o(pc0_o), .pc1_o(pc1_o), .count_o(count_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } ent_t;

  typedef struct packed {
    logic             v0, v1;
    logic [31:0]      i0, i1;
    logic [PC_W-1:0]  p0, p1;
    logic [CNT_W-1:0] cnt;
    logic             stall;
  } exp_t;

  ent_t model[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;
  bit   done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] inst, input logic [ADDR_W-1:0] a, input bit slot);
    ent_t r;
    r.inst = inst;
    r.pc   = PC_W'(a) * PC_W'(8) + (slot ? PC_W'(4) : PC_W'(0));
    return r;
  endfunction

  // Drive one cycle of inputs, predict this cycle's outputs, then advance the model across the edge.
  task automatic cycle(input bit rn, input bit ev, input logic [63:0] d, input logic [ADDR_W-1:0] a,
                       input bit sk, input bit fl, input logic [1:0] dq);
    ent_t inc[$];
    ent_t view[$];
    exp_t e;
    bit   stall, accept;
    int   req, n;
    resetn_i = rn; enq_valid_i = ev; data_i = d; addr_i = a;
    skip_lo_i = sk; flush_i = fl; deq_cnt_i = dq;
    stall  = model.size() > DEPTH - 2;
    accept = ev && !stall && !fl;
    if (accept) begin
      if (!sk) inc.push_back(mk(d[31:0], a, 1'b0));
      inc.push_back(mk(d[63:32], a, 1'b1));
    end
    view = model;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (model.size() == 0 && accept) view = inc;
`endif
    e.v0    = view.size() >= 1;
    e.v1    = view.size() >= 2;
    e.i0    = e.v0 ? view[0].inst : NOP;
    e.p0    = e.v0 ? view[0].pc : '0;
    e.i1    = e.v1 ? view[1].inst : NOP;
    e.p1    = e.v1 ? view[1].pc : '0;
    e.cnt   = CNT_W'(model.size());
    e.stall = stall;
    exp_q.push_back(e);
    started = 1;
    if (!rn || fl) begin
      model.delete();
    end else begin
      req = (dq == 2'd3) ? 2 : int'(dq);
      n   = (req < view.size()) ? req : view.size();
      foreach (inc[i]) model.push_back(inc[i]);
      repeat (n) void'(model.pop_front());
    end
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle(input logic [1:0] dq);
    cycle(1'b1, 1'b0, 64'h0, '0, 1'b0, 1'b0, dq);
  endtask

  task automatic pkt(input logic [ADDR_W-1:0] a, input logic [63:0] d, input bit sk, input logic [1:0] dq);
    cycle(1'b1, 1'b1, d, a, sk, 1'b0, dq);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock_i);
      if (done) break;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid0", valid0_o, e.v0);
        chk("valid1", valid1_o, e.v1);
        chk("inst0", inst0_o, e.i0);
        chk("inst1", inst1_o, e.i1);
        chk("pc0", pc0_o, e.p0);
        chk("pc1", pc1_o, e.p1);
        chk("count", count_o, e.cnt);
        chk("stall", imemstall_o, e.stall);
      end else if (started) begin
        chk("scoreboard_underrun", 64'd0, 64'd1);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] lo, hi;
    resetn_i = 1'b0; enq_valid_i = 1'b0; data_i = '0; addr_i = '0;
    skip_lo_i = 1'b0; flush_i = 1'b0; deq_cnt_i = '0;
    @(posedge clock_i);
    #1;
    cycle(1'b0, 1'b1, 64'h1234, 10'd7, 1'b0, 1'b0, 2'd2);
    cycle(1'b0, 1'b0, 64'h0, '0, 1'b0, 1'b0, 2'd0);

    for (int k = 0; k < 3; k++) begin
      lo = 32'h1111_1111 * (2 * k + 1);
      hi = 32'h1111_1111 * (2 * k + 2);
      pkt(ADDR_W'(k), {hi, lo}, 1'b0, 2'd0);
    end
    chk("tp_count6", count_o, 6);
    chk("tp_inst0", inst0_o, 32'h1111_1111);
    chk("tp_pc0", pc0_o, 13'h000);
    chk("tp_inst1", inst1_o, 32'h2222_2222);
    chk("tp_pc1", pc1_o, 13'h004);
    chk("tp_stall6", imemstall_o, 0);
    pkt(10'd3, {32'h8888_8888, 32'h7777_7777}, 1'b0, 2'd0);
    chk("tp_stall8", imemstall_o, 1);
    pkt(10'd4, {32'h9999_9999, 32'h9999_9990}, 1'b0, 2'd0);
    chk("tp_ignored", count_o, 8);
    idle(2'd1);
    chk("tp_stall7", imemstall_o, 1);
    idle(2'd1);
    chk("tp_unstall6", imemstall_o, 0);
    repeat (3) idle(2'd2);
    chk("tp_drain_valid", valid0_o, 0);
    chk("tp_drain_nop", inst0_o, NOP);

    pkt(10'd5, {32'hAAAA_0005, 32'hBBBB_0005}, 1'b1, 2'd0);
    chk("tp_skip_count", count_o, 1);
    chk("tp_skip_pc", pc0_o, 13'h02C);
    chk("tp_skip_inst", inst0_o, 32'hAAAA_0005);
    idle(2'd2);
    chk("tp_no_underflow", count_o, 0);

    for (int k = 0; k < 20; k++)
      pkt(ADDR_W'(6 + k), {32'hC000_0000 | k, 32'hD000_0000 | k}, 1'b0, 2'd2);
    repeat (2) idle(2'd3);

    for (int k = 0; k < 3; k++) pkt(ADDR_W'(40 + k), {$urandom, $urandom}, 1'b0, 2'd0);
    cycle(1'b1, 1'b1, 64'h5555_5555_6666_6666, 10'd50, 1'b0, 1'b1, 2'd1);
    chk("tp_flush_count", count_o, 0);
    chk("tp_flush_valid", valid0_o, 0);
    chk("tp_flush_stall", imemstall_o, 0);

`ifdef FETCH_QUEUE_BYPASS_EN
    pkt(10'd3, {32'hCCCC_0003, 32'hDDDD_0003}, 1'b0, 2'd1);
    chk("tp_bypass_count", count_o, 1);
    chk("tp_bypass_pc", pc0_o, 13'h01C);
    idle(2'd2);
`endif

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), {$urandom, $urandom},
            ADDR_W'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 32) == 0),
            2'($urandom_range(0, 3)));
    end
    repeat (4) idle(2'd2);

    done = 1;
    @(negedge clock_i);
    @(negedge clock_i);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the instruction memory and the decode stage of the dual-issue core. It accepts 64-bit fetch packets (two 32-bit instructions) from instruction memory and stores them as individual instructions in a circular buffer. It presents the two oldest instructions to decode, which retires 0, 1 or 2 of them per cycle. It back-pressures fetch through a stall signal and discards everything on a pipeline flush.

## Interface
- DEPTH, 8, entries, one 32-bit instruction each; power of two, ≥4
- ADDR_W, 10, width of the instruction-memory packet address
- clock_i  in  1  system clock; all state updates on rising edge
- resetn_i  in  1  reset, synchronous, active-low
- enq_valid_i  in  1  fetch packet present on data_i/addr_i
- data_i  in  64  packet; [31:0] = lower-address instruction (slot 0), [63:32] = slot 1
- addr_i  in  ADDR_W  packet address, 8-byte granularity
- skip_lo_i  in  1  drop slot 0 of this packet (branch target in slot 1)
- imemstall_o  out  1  high = queue cannot accept a packet this cycle
- flush_i  in  1  discard all contents (redirect)
- deq_cnt_i  in  2  instructions consumed by decode this cycle (0, 1, 2)
- valid0_o / valid1_o  out  1  oldest / second-oldest instruction valid
- inst0_o / inst1_o  out  32  oldest / second-oldest instruction
- pc0_o / pc1_o  out  ADDR_W+3  byte address of each instruction
- count_o  out  log2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH entries of {instruction, word index ADDR_W+1 bits}. Head/tail pointers are log2(DEPTH) bits and wrap naturally. A separate occupancy counter distinguishes full from empty.
- Byte PC = {word index, 2'b00}. Word index = {addr_i, slot}.
- imemstall_o = (count_o > DEPTH−2). It is derived from registered count only; there is no combinational path from deq_cnt_i or enq_valid_i.
- Enqueue is accepted when enq_valid_i & !imemstall_o & !flush_i.
  - skip_lo_i=0: writes slot 0 then slot 1 (+2).
  - skip_lo_i=1: writes slot 1 only (+1).
- enq_valid_i while stalled: the packet is ignored. Fetch is responsible for replaying it.
- Dequeue amount = min(deq_cnt_i, count_o). Decode driving more than valid is tolerated and clamped; deq_cnt_i=3 is treated as 2.
- Next count = count + enq_n − deq_n, all computed in one cycle. Enqueue and dequeue in the same cycle are legal.
- Outputs:
  - valid0_o = count≥1; valid1_o = count≥2.
  - An invalid slot drives inst = 32'h00000013 (NOP) and pc = 0.
- flush_i takes priority over both enqueue and dequeue. Next cycle: count=0, head=tail=0.
- Reset (resetn_i=0 at an edge), with or without an operation in flight: count=0, pointers=0, storage contents don't-care.

## Timing
- Reset values: valid0_o=0, valid1_o=0, inst0_o=inst1_o=32'h00000013, pc0_o=pc1_o=0, count_o=0, imemstall_o=0.
- Without bypass: an instruction enqueued at edge N is visible on the outputs after edge N. Dequeue at edge N+1 at the earliest.
- Dequeue at edge N updates the outputs after edge N to the next oldest entries.
- Full boundary: at count=DEPTH−1 or DEPTH, imemstall_o=1. A dequeue in that cycle lowers imemstall_o only after the edge.
- Wrap-around: a packet whose two slots straddle entry DEPTH−1 → 0 is written correctly, slot 1 landing at entry 0.
- Flush in the same cycle as enq_valid_i: the packet is dropped. imemstall_o=0 the next cycle.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count_o=0 and an enqueue is accepted, the incoming instructions drive valid/inst/pc combinationally in the same cycle.
  - deq_cnt_i in that cycle consumes them directly; only unconsumed instructions are written.
  - The imemstall_o rule is unchanged.
- Not defined: no bypass; the minimum enqueue-to-output latency is one cycle.

## Test plan
- Reset, then three packets, no dequeue. Packets at addr 0,1,2 with data {0x22222222,0x11111111}, etc. → count_o 2,4,6. inst0_o=0x11111111 with pc0_o=0x000; inst1_o=0x22222222 with pc1_o=0x004. imemstall_o=1 at count 7/8.
- Dual dequeue drain: with the queue at 6, drive deq_cnt_i=2 for three cycles → count_o 4,2,0. PCs advance by 8. After the drain, valid0_o=0 and inst0_o=0x00000013.
- skip_lo_i: packet at addr 5 with skip_lo_i=1 → count_o=1, pc0_o=0x02C, inst0_o=data_i[63:32].
- Wrap and simultaneous events: 20 cycles of continuous enqueue with deq_cnt_i=2 → pointers wrap, and the PC sequence is strictly +4 with no gaps. Issuing deq_cnt_i=2 at count=1 → count becomes 0, with no underflow.
- Flush: at count=6, assert flush_i with enq_valid_i=1 and deq_cnt_i=1 → next cycle count_o=0, valid0_o=0, imemstall_o=0.
- Bypass (FETCH_QUEUE_BYPASS_EN only): empty queue, enqueue at addr 3 with deq_cnt_i=1 → same cycle valid0_o=1, pc0_o=0x018. Next cycle count_o=1, pc0_o=0x01C.
